// File: rtl/vigna_bus_arbiter.sv
// Round-robin N-master arbiter for the vigna valid/ready bus: 1-cycle grant, then one dead IDLE cycle after each transaction.
// No backpressure beyond the bus handshake: a granted master holds m_valid until m_ready; the optional watchdog ends stuck transfers with m_err.
module vigna_bus_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           m_valid,
    output logic [N-1:0]           m_ready,
    input  logic [32*N-1:0]        m_addr,
    input  logic [32*N-1:0]        m_wdata,
    input  logic [4*N-1:0]         m_wstrb,
    output logic [31:0]            m_rdata,
    output logic [N-1:0]           m_err,
    output logic                   s_valid,
    input  logic                   s_ready,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wstrb,
    input  logic [31:0]            s_rdata,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   grant
);

    localparam int GW = $clog2(N);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] TMO_VAL = WW'(TIMEOUT);
    localparam logic [GW-1:0] LAST_RST = GW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic            cool_q, cool_d;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic            gnt_vld;
    logic            tmo;

    // Rotating priority: the master after the last one served is looked at first.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!win_found && m_valid[(int'(last_q) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = GW'((int'(last_q) + k) % N);
            end
        end
    end

    assign gnt_vld = m_valid[grant_q];
    assign tmo     = (TIMEOUT != 0) && (state_q == BUSY) && (wcnt_q == TMO_VAL);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        cool_d  = 1'b0;
        m_ready = '0;
        m_err   = '0;
        m_rdata = '0;
        s_valid = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;

        case (state_q)
            IDLE: begin
                // cool_q marks the single idle cycle that follows every transaction.
                if (!cool_q && win_found) begin
                    grant_d = win_idx;
                    wcnt_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_addr  = m_addr[32*int'(grant_q) +: 32];
                s_wdata = m_wdata[32*int'(grant_q) +: 32];
                s_wstrb = m_wstrb[4*int'(grant_q) +: 4];
                s_valid = gnt_vld & ~tmo;
                if (!gnt_vld) begin
                    // Master withdrew mid-transfer: abort silently.
                    last_d  = grant_q;
                    cool_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo) begin
                    m_ready[grant_q] = 1'b1;
                    m_err[grant_q]   = 1'b1;
                    last_d  = grant_q;
                    cool_d  = 1'b1;
                    state_d = IDLE;
                end else if (s_ready) begin
                    m_ready[grant_q] = 1'b1;
                    m_rdata = s_rdata;
                    last_d  = grant_q;
                    cool_d  = 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (wcnt_q != TMO_VAL)) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            wcnt_q  <= '0;
            cool_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            cool_q  <= cool_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign grant = grant_q;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed bench for vigna_bus_arbiter (N=4, TIMEOUT=8) with hand-computed expectations.
module tb_vigna_bus_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      m_valid;
    logic [N-1:0]      m_ready;
    logic [32*N-1:0]   m_addr;
    logic [32*N-1:0]   m_wdata;
    logic [4*N-1:0]    m_wstrb;
    logic [31:0]       m_rdata;
    logic [N-1:0]      m_err;
    logic              s_valid;
    logic              s_ready;
    logic [31:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [31:0]       s_rdata;
    logic              busy;
    logic [1:0]        grant;

    int n_cmp = 0;
    int n_bad = 0;

    vigna_bus_arbiter #(.N(N), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_err(m_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_ready = 1'b0;
        s_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_val("rst_s_valid", 32'(s_valid), 32'h0);
        check_val("rst_busy",    32'(busy),    32'h0);
        check_val("rst_grant",   32'(grant),   32'h0);
        check_val("rst_m_ready", 32'(m_ready), 32'h0);
        check_val("rst_m_err",   32'(m_err),   32'h0);
        check_val("rst_m_rdata", m_rdata,      32'h0);
        check_val("rst_s_addr",  s_addr,       32'h0);
        check_val("rst_s_wstrb", 32'(s_wstrb), 32'h0);
        tick();

        // Single master 2 write, 0-wait slave.
        m_valid = 4'b0100;
        m_addr[2*32 +: 32]  = 32'h0000_0100;
        m_wdata[2*32 +: 32] = 32'hA5A5_A5A5;
        m_wstrb[2*4 +: 4]   = 4'hF;
        s_ready = 1'b1;
        #1;
        check_val("t1_idle_svld", 32'(s_valid), 32'h0);
        tick();
        check_val("t1_svld",   32'(s_valid), 32'h1);
        check_val("t1_saddr",  s_addr,       32'h0000_0100);
        check_val("t1_swdata", s_wdata,      32'hA5A5_A5A5);
        check_val("t1_swstrb", 32'(s_wstrb), 32'hF);
        check_val("t1_grant",  32'(grant),   32'h2);
        check_val("t1_busy",   32'(busy),    32'h1);
        check_val("t1_mready", 32'(m_ready), 32'h4);
        tick();
        m_valid = '0;
        #1;
        check_val("t1_done_busy",   32'(busy),    32'h0);
        check_val("t1_done_mready", 32'(m_ready), 32'h0);
        tick();

        // Fairness: all masters request continuously, served every 3 cycles in order 0,1,2,3,0.
        pulse_reset();
        m_valid = 4'b1111;
        s_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            logic [3:0] exp_rdy;
            exp_rdy = (c % 3 == 1) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
            #1;
            check_val($sformatf("fair_mready_c%0d", c), 32'(m_ready), 32'(exp_rdy));
            if (c % 3 == 1)
                check_val($sformatf("fair_grant_c%0d", c), 32'(grant), 32'((c / 3) % 4));
            tick();
        end
        m_valid = '0;
        s_ready = 1'b0;
        tick();

        // Master 1 read with a 5-cycle wait slave.
        m_valid = 4'b0010;
        m_addr[1*32 +: 32] = 32'h0000_0200;
        m_wstrb[1*4 +: 4]  = 4'h0;
        #1;
        check_val("t3_idle_busy", 32'(busy), 32'h0);
        tick();
        for (int w = 0; w < 5; w++) begin
            #1;
            check_val($sformatf("t3_svld_w%0d", w),  32'(s_valid), 32'h1);
            check_val($sformatf("t3_saddr_w%0d", w), s_addr,       32'h0000_0200);
            check_val($sformatf("t3_wstrb_w%0d", w), 32'(s_wstrb), 32'h0);
            check_val($sformatf("t3_mrdy_w%0d", w),  32'(m_ready), 32'h0);
            tick();
        end
        s_ready = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("t3_mready", 32'(m_ready), 32'h2);
        check_val("t3_rdata",  m_rdata,      32'hDEAD_BEEF);
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        #1;
        check_val("t3_after_rdata",  m_rdata,      32'h0);
        check_val("t3_after_mready", 32'(m_ready), 32'h0);
        tick();

        // Timeout on master 3 (TIMEOUT=8) while master 0 waits; last=1 so master 3 wins first.
        m_valid = 4'b1001;
        m_addr[0*32 +: 32] = 32'h0000_0400;
        #1;
        check_val("t4_idle_busy", 32'(busy), 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val($sformatf("t4_svld_%0d", i),  32'(s_valid), 32'h1);
            check_val($sformatf("t4_grant_%0d", i), 32'(grant),   32'h3);
            check_val($sformatf("t4_merr_%0d", i),  32'(m_err),   32'h0);
            tick();
        end
        s_ready = 1'b1;
        s_rdata = 32'h1234_5678;
        #1;
        check_val("t4_tmo_svld",   32'(s_valid), 32'h0);
        check_val("t4_tmo_mready", 32'(m_ready), 32'h8);
        check_val("t4_tmo_merr",   32'(m_err),   32'h8);
        check_val("t4_tmo_rdata",  m_rdata,      32'h0);
        tick();
        m_valid = 4'b0001;
        s_ready = 1'b0;
        #1;
        check_val("t4_dead_busy",   32'(busy),    32'h0);
        check_val("t4_dead_mready", 32'(m_ready), 32'h0);
        tick();
        check_val("t4_arb_busy", 32'(busy), 32'h0);
        tick();
        check_val("t4_next_grant", 32'(grant),   32'h0);
        check_val("t4_next_busy",  32'(busy),    32'h1);
        check_val("t4_next_svld",  32'(s_valid), 32'h1);

        // Non-preemption: master 1 requests while master 0 is in a 4-wait transfer.
        m_valid = 4'b0011;
        #1;
        check_val("t5_grant_w0", 32'(grant), 32'h0);
        tick();
        for (int i = 1; i < 4; i++) begin
            check_val($sformatf("t5_grant_w%0d", i), 32'(grant),   32'h0);
            check_val($sformatf("t5_mrdy_w%0d", i),  32'(m_ready), 32'h0);
            tick();
        end
        s_ready = 1'b1;
        #1;
        check_val("t5_done_mready", 32'(m_ready), 32'h1);
        check_val("t5_done_grant",  32'(grant),   32'h0);
        tick();
        m_valid = 4'b0010;
        #1;
        check_val("t5_dead_grant", 32'(grant), 32'h0);
        check_val("t5_dead_busy",  32'(busy),  32'h0);
        tick();
        check_val("t5_arb_grant", 32'(grant), 32'h0);
        tick();
        check_val("t5_new_grant",  32'(grant),   32'h1);
        check_val("t5_new_mready", 32'(m_ready), 32'h2);
        tick();
        m_valid = '0;
        s_ready = 1'b0;
        tick();

        // Reset in the middle of a master 2 transfer.
        m_valid = 4'b0100;
        m_addr[2*32 +: 32] = 32'h0000_0300;
        #1;
        check_val("t6_idle_busy", 32'(busy), 32'h0);
        tick();
        check_val("t6_busy",  32'(busy),  32'h1);
        check_val("t6_grant", 32'(grant), 32'h2);
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_valid = 4'b0101;
        #1;
        check_val("t6_rst_svld",   32'(s_valid), 32'h0);
        check_val("t6_rst_busy",   32'(busy),    32'h0);
        check_val("t6_rst_mready", 32'(m_ready), 32'h0);
        check_val("t6_rst_grant",  32'(grant),   32'h0);
        tick();
        check_val("t6_post_grant", 32'(grant),   32'h0);
        check_val("t6_post_saddr", s_addr,       32'h0000_0400);
        check_val("t6_post_svld",  32'(s_valid), 32'h1);
        m_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
